// File: rtl/num_overlay.sv
// Decimal number overlay: a sequential double-dabble converter feeds display registers,
// and a two-stage pixel pipeline renders the digits through an external character ROM.
module num_overlay #(
    parameter int DIGITS = 5,
    parameter int VW     = 17,
    parameter int GW     = 15,
    parameter int GH     = 16
) (
    input  logic            clk_pix,
    input  logic            rst_n,
    input  logic [10:0]     x,
    input  logic [10:0]     y,
    input  logic            frame_start,
    input  logic [VW-1:0]   value,
    input  logic [9:0]      x0,
    input  logic [9:0]      y0,
    input  logic            highlight,
    input  logic [23:0]     fg_rgb,
    input  logic [23:0]     hl_rgb,
    output logic [7:0]      glyph_code,
    output logic [3:0]      glyph_row,
    input  logic [GW-1:0]   glyph_bits,
    output logic            en,
    output logic [7:0]      red,
    output logic [7:0]      green,
    output logic [7:0]      blue,
    output logic            busy,
    output logic            ovf
);
    // BCD digits needed for a VW-bit value never exceed (VW+2)/3
    localparam int ND    = (VW + 2) / 3;
    localparam int BN    = (ND > DIGITS) ? ND : DIGITS;
    localparam int BW    = 4 * BN;
    localparam int CNT_W = $clog2(VW + 1);
    localparam int CW    = (GW > 1) ? $clog2(GW) : 1;
    localparam int NW    = $clog2(DIGITS) + 1;
    localparam logic [11:0] BOX_W = 12'(GW * DIGITS);
    localparam logic [11:0] BOX_H = 12'(GH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                state;
    logic [VW-1:0]         bin;
    logic [BW-1:0]         bcd;
    logic [CNT_W-1:0]      bit_cnt;
    logic [4*DIGITS-1:0]   pend_bcd;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  pend_vld;
    logic                  pend_ovf;
    logic                  disp_ovf;

    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i < BN; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic bcd_ovf(input logic [BW-1:0] b);
        logic o;
        o = 1'b0;
        for (int i = DIGITS; i < BN; i++) o = o | (|b[4*i +: 4]);
        return o;
    endfunction

    // frame_start has priority in every state: it restarts conversion and discards partial work
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            bin      <= '0;
            bcd      <= '0;
            bit_cnt  <= '0;
            pend_vld <= 1'b0;
            pend_ovf <= 1'b0;
            pend_bcd <= '0;
            disp_bcd <= '0;
            disp_ovf <= 1'b0;
        end else if (frame_start) begin
            if (pend_vld) begin
                disp_bcd <= pend_bcd;
                disp_ovf <= pend_ovf;
                pend_vld <= 1'b0;
            end
            bin     <= value;
            bcd     <= '0;
            bit_cnt <= '0;
            state   <= SHIFT;
            busy    <= 1'b1;
        end else begin
            case (state)
                SHIFT: begin
                    {bcd, bin} <= {dabble_adj(bcd), bin} << 1;
                    bit_cnt    <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_W'(VW - 1)) state <= DONE;
                end
                DONE: begin
                    pend_bcd <= bcd[4*DIGITS-1:0];
                    pend_ovf <= bcd_ovf(bcd);
                    pend_vld <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ovf = disp_ovf;

    logic [7:0] cell_code [DIGITS];

    always_comb begin : render
        logic       lead;
        logic [3:0] d;
        lead = 1'b1;
        d    = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            d = disp_bcd[4*(DIGITS-1-i) +: 4];
            if (d != 4'd0 || i == DIGITS - 1) lead = 1'b0;
            if (disp_ovf)  cell_code[i] = 8'h2D;
            else if (lead) cell_code[i] = 8'h20;
            else           cell_code[i] = 8'h30 + {4'h0, d};
        end
    end

    logic [11:0]   xe, ye, x0e, y0e;
    logic          in_box;
    logic [CW-1:0] col_cnt, cur_col, col_p1;
    logic [NW-1:0] cell_cnt, cur_cell;
    logic [7:0]    sel_code;
    logic          in_box_p1, hl_p1;
    logic [GW-1:0] bits_sh;
    logic          pix_on;

    assign xe     = {1'b0, x};
    assign ye     = {1'b0, y};
    assign x0e    = {2'b00, x0};
    assign y0e    = {2'b00, y0};
    assign in_box = (xe >= x0e) && (xe < x0e + BOX_W) && (ye >= y0e) && (ye < y0e + BOX_H);

    assign cur_col  = (x == {1'b0, x0}) ? '0 : col_cnt;
    assign cur_cell = (x == {1'b0, x0}) ? '0 : cell_cnt;

    always_comb begin
        sel_code = 8'h20;
        for (int i = 0; i < DIGITS; i++) begin
            if (cur_cell == NW'(i)) sel_code = cell_code[i];
        end
    end

    always_ff @(posedge clk_pix) begin
        col_cnt  <= (cur_col == CW'(GW - 1)) ? '0 : cur_col + 1'b1;
        cell_cnt <= (cur_col == CW'(GW - 1)) ? cur_cell + 1'b1 : cur_cell;
        col_p1   <= cur_col;
        hl_p1    <= highlight;
    end

    // stage 1: ROM address from the current x,y
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            glyph_code <= 8'h20;
            glyph_row  <= 4'd0;
            in_box_p1  <= 1'b0;
        end else begin
            glyph_code <= in_box ? sel_code : 8'h20;
            glyph_row  <= 4'(ye - y0e);
            in_box_p1  <= in_box;
        end
    end

    assign bits_sh = glyph_bits << col_p1;
    assign pix_on  = in_box_p1 & bits_sh[GW-1];

    // stage 2: ROM row data returned, pick the column bit and colour
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            en                 <= 1'b0;
            {red, green, blue} <= 24'h0;
        end else begin
            en                 <= pix_on;
            {red, green, blue} <= pix_on ? (hl_p1 ? hl_rgb : fg_rgb) : 24'h0;
        end
    end

endmodule

// File: tb/tb_num_overlay.sv
// Randomized scan-frame bench for num_overlay with an arithmetic reference model.
module tb_num_overlay;
    localparam int DIGITS = 5;
    localparam int VW     = 17;
    localparam int GW     = 15;
    localparam int GH     = 16;

    logic          clk_pix = 1'b0;
    logic          rst_n   = 1'b0;
    logic [10:0]   x = '0, y = '0;
    logic          frame_start = 1'b0;
    logic [VW-1:0] value = '0;
    logic [9:0]    x0 = 10'd100, y0 = 10'd80;
    logic          highlight = 1'b0;
    logic [23:0]   fg_rgb = 24'h11AA33, hl_rgb = 24'hFF8000;
    logic [7:0]    glyph_code;
    logic [3:0]    glyph_row;
    logic [GW-1:0] glyph_bits;
    logic          en, busy, ovf;
    logic [7:0]    red, green, blue;
    int            rom_ofs = 0;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    num_overlay #(.DIGITS(DIGITS), .VW(VW), .GW(GW), .GH(GH)) dut (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(x), .y(y), .frame_start(frame_start),
        .value(value), .x0(x0), .y0(y0), .highlight(highlight), .fg_rgb(fg_rgb),
        .hl_rgb(hl_rgb), .glyph_code(glyph_code), .glyph_row(glyph_row),
        .glyph_bits(glyph_bits), .en(en), .red(red), .green(green), .blue(blue),
        .busy(busy), .ovf(ovf)
    );

    always #5 clk_pix = ~clk_pix;

    // walking-one character ROM: one ink column per (code,row), combinational
    function automatic logic [GW-1:0] rom(input logic [7:0] c, input logic [3:0] r, input int ofs);
        logic [GW-1:0] b;
        int p;
        p = (int'(c) + int'(r) + ofs) % GW;
        b = '0;
        b[GW-1-p] = 1'b1;
        return b;
    endfunction

    assign glyph_bits = rom(glyph_code, glyph_row, rom_ofs);

    function automatic logic [7:0] exp_char(input int val, input int k);
        int p;
        if (val > 10**DIGITS - 1) return 8'h2D;
        p = 10**(DIGITS - 1 - k);
        if (k < DIGITS - 1 && val < p) return 8'h20;
        return 8'(48 + (val / p) % 10);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40) $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // reference model state
    int          m_disp = 0, m_pend = 0, m_conv = 0, m_cnt = 0;
    bit          m_pend_vld = 1'b0;
    bit          s1_in = 1'b0, s1_hl = 1'b0;
    logic [7:0]  s1_code = 8'h20;
    logic [3:0]  s1_row = 4'd0;
    int          s1_col = 0;
    logic [7:0]  e_code = 8'h20;
    logic [3:0]  e_row = 4'd0;
    bit          e_en = 1'b0;
    logic [23:0] e_rgb = 24'h0;

    task automatic model_step();
        logic [GW-1:0] mb;
        int dx, my;
        bit inb;
        if (!rst_n) begin
            m_disp = 0; m_pend_vld = 1'b0; m_cnt = 0; s1_in = 1'b0;
            e_code = 8'h20; e_row = 4'd0; e_en = 1'b0; e_rgb = 24'h0;
            return;
        end
        if (s1_in) begin
            mb   = rom(s1_code, s1_row, rom_ofs);
            e_en = mb[GW-1-s1_col];
        end else e_en = 1'b0;
        e_rgb = e_en ? (s1_hl ? hl_rgb : fg_rgb) : 24'h0;
        dx  = int'(x) - int'(x0);
        my  = int'(y);
        inb = dx >= 0 && dx < GW*DIGITS && my >= int'(y0) && my < int'(y0) + GH;
        s1_in   = inb;
        s1_code = inb ? exp_char(m_disp, dx / GW) : 8'h20;
        s1_row  = 4'(my - int'(y0));
        s1_col  = inb ? dx % GW : 0;
        s1_hl   = highlight;
        e_code  = s1_code;
        e_row   = s1_row;
        if (frame_start) begin
            if (m_pend_vld) begin m_disp = m_pend; m_pend_vld = 1'b0; end
            m_conv = int'(value);
            m_cnt  = VW + 1;
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin m_pend = m_conv; m_pend_vld = 1'b1; end
        end
    endtask

    initial forever begin
        @(posedge clk_pix or negedge rst_n);
        model_step();
    end

    always @(negedge clk_pix) begin
        if (chk_on) begin
            chk("glyph_code", 32'(glyph_code), 32'(e_code));
            chk("glyph_row", 32'(glyph_row), 32'(e_row));
            chk("en", 32'(en), 32'(e_en));
            chk("rgb", 32'({red, green, blue}), 32'(e_rgb));
            chk("busy", 32'(busy), 32'(m_cnt > 0));
            chk("ovf", 32'(ovf), 32'(m_disp > 10**DIGITS - 1));
        end
    end

    logic [7:0]  cap [DIGITS];
    logic        en_org, en_left, en_right;
    logic [23:0] rgb_org;
    int          qx1 = -100, qy1 = -100, qx2 = -100, qy2 = -100;

    task automatic frame(input int v, input int fs2_at, input int v2, input int hl_sel,
                         input int rst_at, output int busy_n);
        int c;
        logic hl;
        c = 0;
        busy_n = 0;
        for (int k = 0; k < DIGITS; k++) cap[k] = 'x;
        en_org = 'x; en_left = 'x; en_right = 'x; rgb_org = 'x;
        for (int yy = int'(y0) - 1; yy <= int'(y0) + GH; yy++) begin
            hl = (hl_sel == 2) ? 1'($urandom_range(0, 1)) : 1'(hl_sel);
            for (int xx = int'(x0) - 2; xx <= int'(x0) + GW*DIGITS + 1; xx++) begin
                @(negedge clk_pix);
                if (busy === 1'b1) busy_n++;
                if (qy1 == int'(y0) && qx1 >= int'(x0) && qx1 < int'(x0) + GW*DIGITS
                    && (qx1 - int'(x0)) % GW == 0)
                    cap[(qx1 - int'(x0)) / GW] = glyph_code;
                if (qy2 == int'(y0) && qx2 == int'(x0)) begin
                    en_org = en; rgb_org = {red, green, blue};
                end
                if (qy2 == int'(y0) && qx2 == int'(x0) - 1) en_left = en;
                if (qy2 == int'(y0) && qx2 == int'(x0) + GW*DIGITS) en_right = en;
                x = 11'(xx);
                y = 11'(yy);
                highlight = hl;
                frame_start = (c == 0) || (c == fs2_at);
                if (c == 0) value = VW'(v);
                else if (c == fs2_at) value = VW'(v2);
                if (c == rst_at) begin
                    #2 rst_n = 1'b0;
                    #1;
                    chk("rst_busy", 32'(busy), 32'd0);
                    chk("rst_code", 32'(glyph_code), 32'h20);
                    chk("rst_en", 32'(en), 32'd0);
                    chk("rst_ovf", 32'(ovf), 32'd0);
                end
                if (c == rst_at + 3) #2 rst_n = 1'b1;
                qx2 = qx1; qy2 = qy1; qx1 = xx; qy1 = yy;
                c++;
            end
        end
    endtask

    task automatic check_caps(input string nm, input logic [39:0] codes);
        for (int k = 0; k < DIGITS; k++)
            chk(nm, 32'(cap[k]), 32'(codes[8*(DIGITS-1-k) +: 8]));
    endtask

    int bn;

    initial begin
        repeat (3) @(negedge clk_pix);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ovf", 32'(ovf), 32'd0);
        chk("reset_code", 32'(glyph_code), 32'h20);
        chk("reset_row", 32'(glyph_row), 32'd0);
        chk("reset_en", 32'(en), 32'd0);
        chk("reset_rgb", 32'({red, green, blue}), 32'd0);
        chk_on = 1'b1;
        @(negedge clk_pix);
        #2 rst_n = 1'b1;

        frame(12345, -1, 0, 0, -1, bn);
        check_caps("cells_reset0", 40'h2020202030);
        chk("busy_len", 32'(bn), 32'd18);
        frame(7, -1, 0, 0, -1, bn);
        check_caps("cells_12345", 40'h3132333435);
        chk("busy_len2", 32'(bn), 32'd18);
        frame(100000, -1, 0, 0, -1, bn);
        check_caps("cells_7", 40'h2020202037);
        frame(555, 5, 42, 0, -1, bn);
        check_caps("cells_ovf", 40'h2D2D2D2D2D);
        chk("ovf_set", 32'(ovf), 32'd1);
        frame(9, -1, 0, 0, -1, bn);
        check_caps("cells_42", 40'h2020203432);
        chk("ovf_clr", 32'(ovf), 32'd0);

        rom_ofs = 13;
        frame(9, -1, 0, 0, -1, bn);
        chk("origin_en", 32'(en_org), 32'd1);
        chk("origin_fg", 32'(rgb_org), 32'(fg_rgb));
        chk("left_en", 32'(en_left), 32'd0);
        chk("right_en", 32'(en_right), 32'd0);
        frame(9, -1, 0, 1, -1, bn);
        chk("origin_en_hl", 32'(en_org), 32'd1);
        chk("origin_hl", 32'(rgb_org), 32'(hl_rgb));

        frame(321, -1, 0, 0, 8, bn);
        frame(5, -1, 0, 0, -1, bn);
        check_caps("cells_after_rst", 40'h2020202030);
        frame(6, -1, 0, 0, -1, bn);
        check_caps("cells_5", 40'h2020202035);

        for (int i = 0; i < 8; i++) begin
            x0      = 10'($urandom_range(2, 1000));
            y0      = 10'($urandom_range(1, 1000));
            rom_ofs = int'($urandom_range(0, 14));
            frame(int'($urandom_range(0, 131071)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 25)) : -1,
                  int'($urandom_range(0, 131071)), 2, -1, bn);
        end

        @(negedge clk_pix);
        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
